tile_sequencer: RTL

Control sequencer for the mlp_conv compute engine. It turns a level-style start bit from the control register into a run of per-tile engine start pulses and steps a tile index. It waits for the engine's done pulse between tiles, then reports completion through a sticky DONE level and a one-cycle IRQ pulse. It also provides abort and a per-tile watchdog timeout.

---
 rtl/tile_sequencer_if.sv | 29 ++
 rtl/tile_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/tile_sequencer_if.sv
// tile_sequencer_if: control-register and engine handshake bundle for tile_sequencer.
//   master : control side (drives START_LVL, ABORT, NUM_TILES and the engine's
//            ENG_READY/ENG_DONE; observes ENG_START, TILE_IDX, BUSY, DONE, IRQ, ERR)
//   slave  : the sequencer itself (directions mirrored)
interface tile_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             START_LVL;
  logic             ABORT;
  logic [CNT_W-1:0] NUM_TILES;
  logic             ENG_READY;
  logic             ENG_DONE;
  logic             ENG_START;
  logic [CNT_W-1:0] TILE_IDX;
  logic             BUSY;
  logic             DONE;
  logic             IRQ;
  logic             ERR;

  modport master (
    output START_LVL, ABORT, NUM_TILES, ENG_READY, ENG_DONE,
    input  ENG_START, TILE_IDX, BUSY, DONE, IRQ, ERR
  );

  modport slave (
    input  START_LVL, ABORT, NUM_TILES, ENG_READY, ENG_DONE,
    output ENG_START, TILE_IDX, BUSY, DONE, IRQ, ERR
  );
endinterface

// File: rtl/tile_sequencer.sv
// tile_sequencer: turns a 0->1 edge on START_LVL into a run of NUM_TILES engine
// start pulses, stepping TILE_IDX and waiting for ENG_DONE between tiles.
// Completion raises sticky DONE plus a one-cycle IRQ; a per-tile watchdog sets
// sticky ERR and ends the run; ABORT returns to idle silently.
// Ports:
//   CLK    : clock, rising edge
//   RESETN : asynchronous active-low reset
//   bus    : tile_sequencer_if.slave (START_LVL, ABORT, NUM_TILES, ENG_READY,
//            ENG_DONE in; ENG_START, TILE_IDX, BUSY, DONE, IRQ, ERR out)
module tile_sequencer #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TIMEOUT_W = 20
) (
  input logic                CLK,
  input logic                RESETN,
  tile_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_e;

  state_e               state_q, state_d;
  logic                 start_prev_q, start_prev_d;
  logic                 eng_start_q, eng_start_d;
  logic [CNT_W-1:0]     tile_idx_q, tile_idx_d;
  logic [CNT_W-1:0]     n_q, n_d;
  logic                 done_q, done_d;
  logic                 irq_q, irq_d;
  logic                 err_q, err_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

  logic                 start_edge;
  logic [CNT_W-1:0]     n_last;
  logic [TIMEOUT_W-1:0] wait_cnt;

  always_comb begin
    state_d      = state_q;
    start_prev_d = bus.START_LVL;
    eng_start_d  = 1'b0;
    tile_idx_d   = tile_idx_q;
    n_d          = n_q;
    done_d       = done_q;
    irq_d        = 1'b0;
    err_d        = err_q;
    wdog_d       = wdog_q;

    start_edge = bus.START_LVL & ~start_prev_q;
    n_last     = n_q - CNT_W'(1);
    // wdog_q counts completed WAIT cycles, so wait_cnt numbers the current one;
    // expiry on the (2^TIMEOUT_W-1)th cycle keeps the counter from ever wrapping.
    wait_cnt   = wdog_q + TIMEOUT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start_edge && !bus.ABORT) begin
          n_d        = bus.NUM_TILES;
          tile_idx_d = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          state_d    = (bus.NUM_TILES == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.ABORT) begin
          state_d = S_IDLE;
        end else if (bus.ENG_READY) begin
          eng_start_d = 1'b1;
          wdog_d      = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.ABORT) begin
          state_d = S_IDLE;
        end else if (bus.ENG_DONE) begin
          if (tile_idx_q == n_last) begin
            state_d = S_FINISH;
          end else begin
            tile_idx_d = tile_idx_q + CNT_W'(1);
            state_d    = S_ISSUE;
          end
        end else if (wait_cnt == '1) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          wdog_d = wait_cnt;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        if (!bus.ABORT) begin
          done_d = 1'b1;
          irq_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b1;
      eng_start_q  <= 1'b0;
      tile_idx_q   <= '0;
      n_q          <= '0;
      done_q       <= 1'b0;
      irq_q        <= 1'b0;
      err_q        <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      eng_start_q  <= eng_start_d;
      tile_idx_q   <= tile_idx_d;
      n_q          <= n_d;
      done_q       <= done_d;
      irq_q        <= irq_d;
      err_q        <= err_d;
      wdog_q       <= wdog_d;
    end
  end

  assign bus.ENG_START = eng_start_q;
  assign bus.TILE_IDX  = tile_idx_q;
  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.DONE      = done_q;
  assign bus.IRQ       = irq_q;
  assign bus.ERR       = err_q;

endmodule
